fc_classifier: RTL and testbench
================================

# fc_classifier

Fully connected output stage downstream of the convolution/pool/flatten engine. Once that engine deasserts busy, the L2 (flattened, 2048 × 20-bit Q4.16) memory holds the final feature vector. This block then streams that vector once per class against a weight ROM, adds a per-class bias, and rounds and saturates each score. It writes every score to a result memory and reports the arg-max class.

## Interface
- `N_CLASS`, default 4: number of output classes.
- `VEC_LEN`, default 2048: feature vector length; fixed to the L2 memory depth.
- `WAW`, default 14: weight ROM address width; must satisfy 2^WAW ≥ N_CLASS·VEC_LEN + N_CLASS.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `busy` out 1: high from the cycle after an accepted `start` until DONE.
- `done` out 1: one-cycle pulse in DONE.
- `fm_rd` out 1: feature memory read enable.
- `fm_addr` out 11: feature address.
- `fm_data` in 20: signed Q4.16, valid the cycle after `fm_rd`.
- `w_rd` out 1: weight ROM read enable.
- `w_addr` out WAW: weight ROM address.
- `w_data` in 20: signed Q4.16, valid the cycle after `w_rd`.
- `res_wr` out 1: score write strobe.
- `res_addr` out $clog2(N_CLASS): class index.
- `res_data` out 20: signed Q4.16 score.
- `class_idx` out $clog2(N_CLASS): arg-max result, held until the next accepted `start`.

## Operation
- **ROM map:**
  - Weight for class c, element i is at c·VEC_LEN + i.
  - Bias for class c is at N_CLASS·VEC_LEN + c.
- **States:** IDLE → FETCH → LAST → ROUND → WRITE, then FETCH (next class) or DONE → IDLE.
- **IDLE:**
  - All strobes are low.
  - `start` moves to FETCH and clears `cls`, `i`, `acc` and the arg-max registers.
- **FETCH:**
  - Lasts VEC_LEN cycles.
  - `fm_rd` = `w_rd` = 1, with `fm_addr` = i and `w_addr` = cls·VEC_LEN + i; i increments.
  - From the second FETCH cycle on, `acc += fm_data·w_data`.
- **LAST:**
  - Accumulates the final product.
  - Issues `w_rd` at the bias address; `fm_rd` = 0.
- **ROUND:**
  - Computes `s = acc + (w_data <<< 16)`.
  - Rounds half-up: `r = (s + 2^15) >>> 16`.
  - Saturates `r` to [0x80000, 0x7FFFF] and registers it as `score`.
- **WRITE:**
  - `res_wr` = 1, `res_addr` = cls, `res_data` = score.
  - Updates the arg-max: class 0 loads unconditionally; class c replaces it only if `score` is strictly greater, so ties keep the lower index.
  - If cls = N_CLASS−1, go to DONE; otherwise cls++, i = 0, `acc` = 0, go to FETCH.
- **DONE:**
  - `done` = 1 for one cycle; `busy` falls at the next edge.
  - `class_idx` is valid from DONE onward.
- **Arithmetic widths:**
  - Product is 40-bit signed Q8.32.
  - `acc` is 52-bit signed; it cannot overflow for VEC_LEN ≤ 2048.
  - Bias is sign-extended before the add.
- **Boundary conditions:**
  - `start` outside IDLE is ignored.
  - `reset` low at any time asynchronously returns to IDLE.
  - Memory contents are never modified; only the result port writes.

## Timing
- **Reset values:** every output is 0; `class_idx` is 0.
- **Latency:** `start` accepted at cycle 0 → FETCH cycles 1..VEC_LEN. Per class, VEC_LEN+3 cycles.
- **Completion:** DONE occurs at cycle N_CLASS·(VEC_LEN+3)+1, which is 8205 with the defaults.
- **Read ports:** both are synchronous with 1-cycle latency. No back-pressure; the memories must return data every cycle.
- **Result writes:** `res_wr` pulses are exactly VEC_LEN+3 cycles apart.

## Structure
- **Shared package:**
  - State encoding.
  - `Q_FRAC` = 16.
  - Saturation limits `SAT_MAX` = 20'h7FFFF and `SAT_MIN` = 20'h80000.
  - Accumulator width constant.
  - These are shared with the convolution stage's fixed-point constants.
- **Sub-module:** `fc_round_sat`, a combinational 52-bit-in to 20-bit-out round and saturate unit. It is reusable by the convolution stage.

## Test plan
- **Normal run:**
  - Stimulus: `fm_data` = 0x10000 everywhere, biases 0; per-class weights 0x00010, 0x00040, 0x00200, 0xFFC00.
  - Required: scores 0x08000, 0x20000, 0x7FFFF (saturated high), 0x80000 (saturated low); `class_idx` = 2; `done` at cycle 8205.
- **Rounding:**
  - Stimulus: fm[0] = 0x00001, w[0] = 0x08000, all other entries 0, bias 0.
  - Required: score 0x00001. With w[0] = 0x07FFF instead, score 0x00000.
- **Bias and tie:**
  - Stimulus: all weights 0; biases 0x01310, 0xF7295, 0x01310, 0x00000.
  - Required: scores equal the biases; `class_idx` = 0 (tie keeps the lower index).
- **Start while busy:**
  - Stimulus: `start` pulses at cycles 5 and 4000.
  - Required: no restart; exactly N_CLASS `res_wr` pulses with `res_addr` 0..3 in order.
- **Reset mid-operation:**
  - Stimulus: `reset` low at cycle 3000.
  - Required: all outputs 0 immediately; a fresh `start` reproduces the full normal-run results.
- **Address sweep:**
  - Checker verifies that `fm_addr` covers 0..2047 contiguously for each class.
  - Checker verifies that each bias address N_CLASS·VEC_LEN + c is issued exactly once per class.

Source files
------------

// File: rtl/fc_classifier_pkg.sv
// Shared fixed-point constants and FSM encoding for the FC output stage.
// The Q4.16 limits are the same ones the convolution stage rounds against.
package fc_classifier_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LAST, S_ROUND, S_WRITE, S_DONE
  } fc_state_e;

  localparam int D_W    = 20;
  localparam int Q_FRAC = 16;
  localparam int PROD_W = 2 * D_W;
  localparam int ACC_W  = 52;

  localparam logic [D_W-1:0] SAT_MAX = 20'h7FFFF;
  localparam logic [D_W-1:0] SAT_MIN = 20'h80000;
endpackage

// File: rtl/fc_round_sat.sv
// Round-half-up and saturate a Q.32 accumulator down to a Q4.16 word.
import fc_classifier_pkg::*;

module fc_round_sat (
  input  logic signed [ACC_W-1:0] sum,
  output logic        [D_W-1:0]   score
);
  localparam logic signed [ACC_W-1:0] HALF =
    {{(ACC_W-Q_FRAC){1'b0}}, 1'b1, {(Q_FRAC-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] HI = {{(ACC_W-D_W){1'b0}}, SAT_MAX};
  localparam logic signed [ACC_W-1:0] LO = {{(ACC_W-D_W){1'b1}}, SAT_MIN};

  logic signed [ACC_W-1:0] rnd;

  always_comb begin
    rnd = (sum + HALF) >>> Q_FRAC;
    if (rnd > HI)      score = SAT_MAX;
    else if (rnd < LO) score = SAT_MIN;
    else               score = rnd[D_W-1:0];
  end
endmodule

// File: rtl/fc_classifier.sv
// Fully connected classifier: one dot product per class over the flattened
// feature vector, plus bias, round/saturate, result write and arg-max.
import fc_classifier_pkg::*;

module fc_classifier #(
  parameter int N_CLASS = 4,
  parameter int VEC_LEN = 2048,
  parameter int WAW     = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       fm_rd,
  output logic [$clog2(VEC_LEN)-1:0] fm_addr,
  input  logic [D_W-1:0]             fm_data,
  output logic                       w_rd,
  output logic [WAW-1:0]             w_addr,
  input  logic [D_W-1:0]             w_data,
  output logic                       res_wr,
  output logic [$clog2(N_CLASS)-1:0] res_addr,
  output logic [D_W-1:0]             res_data,
  output logic [$clog2(N_CLASS)-1:0] class_idx
);
  localparam int IW = $clog2(VEC_LEN);
  localparam int CW = $clog2(N_CLASS);
  localparam logic [WAW-1:0] BIAS_BASE = WAW'(N_CLASS * VEC_LEN);

  fc_state_e state, state_nx;

  logic [CW-1:0]           cls, best_idx;
  logic [IW-1:0]           i;
  logic signed [ACC_W-1:0] acc, sum;
  logic signed [PROD_W-1:0] prod;
  logic [D_W-1:0]          score, score_nx, best_score;
  logic                    prod_vld;
  logic                    last_i, last_cls;

  assign last_i    = (i == IW'(VEC_LEN - 1));
  assign last_cls  = (cls == CW'(N_CLASS - 1));
  assign prod      = $signed(fm_data) * $signed(w_data);
  // In ROUND the weight port carries the bias read issued from LAST.
  assign sum       = acc + (ACC_W'($signed(w_data)) <<< Q_FRAC);
  assign class_idx = best_idx;

  fc_round_sat u_round_sat (.sum(sum), .score(score_nx));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    fm_rd    = 1'b0;
    fm_addr  = '0;
    w_rd     = 1'b0;
    w_addr   = '0;
    res_wr   = 1'b0;
    res_addr = '0;
    res_data = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        fm_rd   = 1'b1;
        w_rd    = 1'b1;
        fm_addr = i;
        w_addr  = WAW'(cls) * WAW'(VEC_LEN) + WAW'(i);
        if (last_i) state_nx = S_LAST;
      end
      S_LAST: begin
        w_rd     = 1'b1;
        w_addr   = BIAS_BASE + WAW'(cls);
        state_nx = S_ROUND;
      end
      S_ROUND: state_nx = S_WRITE;
      S_WRITE: begin
        res_wr   = 1'b1;
        res_addr = cls;
        res_data = score;
        state_nx = last_cls ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cls        <= '0;
      i          <= '0;
      acc        <= '0;
      prod_vld   <= 1'b0;
      score      <= '0;
      best_score <= '0;
      best_idx   <= '0;
    end else begin
      // Memory data lags the read by a cycle, so only accumulate after a FETCH.
      prod_vld <= (state == S_FETCH);
      case (state)
        S_IDLE: if (start) begin
          cls        <= '0;
          i          <= '0;
          acc        <= '0;
          best_score <= '0;
          best_idx   <= '0;
        end
        S_FETCH: begin
          i <= last_i ? '0 : i + 1'b1;
          if (prod_vld) acc <= acc + ACC_W'(prod);
        end
        S_LAST:  acc   <= acc + ACC_W'(prod);
        S_ROUND: score <= score_nx;
        S_WRITE: begin
          if (cls == '0 || $signed(score) > $signed(best_score)) begin
            best_score <= score;
            best_idx   <= cls;
          end
          if (!last_cls) begin
            cls <= cls + 1'b1;
            i   <= '0;
            acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_classifier.sv
// Directed + randomized bench for fc_classifier against a dot-product model.
module tb_fc_classifier;
  localparam int N = 4, V = 2048, WAW = 14, PER = V + 3;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic busy, done, fm_rd, w_rd, res_wr;
  logic [10:0] fm_addr;
  logic [WAW-1:0] w_addr;
  logic [19:0] fm_data = '0, w_data = '0, res_data;
  logic [1:0] res_addr, class_idx;
  logic [63:0] outs;

  always #5 clk = ~clk;

  fc_classifier #(.N_CLASS(N), .VEC_LEN(V), .WAW(WAW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .fm_rd(fm_rd), .fm_addr(fm_addr), .fm_data(fm_data),
    .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
    .res_wr(res_wr), .res_addr(res_addr), .res_data(res_data),
    .class_idx(class_idx)
  );

  assign outs = 64'({busy, done, fm_rd, fm_addr, w_rd, w_addr,
                     res_wr, res_addr, res_data, class_idx});

  logic [19:0] fm_mem [V];
  logic [19:0] w_mem [1 << WAW];

  always @(posedge clk) begin
    if (fm_rd) fm_data <= fm_mem[fm_addr];
    if (w_rd)  w_data  <= w_mem[w_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: result writes, feature/weight address sweep, bias reads.
  logic [1:0]  r_addr [$];
  logic [19:0] r_data [$];
  int          r_cyc  [$];
  int fm_cnt, sweep_err;
  int bias_cnt [N];

  always @(negedge clk) begin
    if (!reset || (start && !busy)) begin
      r_addr.delete(); r_data.delete(); r_cyc.delete();
      fm_cnt = 0; sweep_err = 0;
      for (int c = 0; c < N; c++) bias_cnt[c] = 0;
    end else begin
      if (res_wr) begin
        r_addr.push_back(res_addr); r_data.push_back(res_data); r_cyc.push_back(cyc);
      end
      if (fm_rd) begin
        if (fm_addr != 11'(fm_cnt % V) || w_addr != WAW'(fm_cnt)) sweep_err++;
        fm_cnt++;
      end
      if (w_rd && !fm_rd) begin
        if (int'(w_addr) >= N * V && int'(w_addr) < N * V + N) bias_cnt[int'(w_addr) - N * V]++;
        else sweep_err++;
      end
    end
  end

  int errs = 0, checks = 0, g_t0 = 0;
  logic [19:0] exp_s [N];
  int exp_idx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model();
    longint acc, r;
    for (int c = 0; c < N; c++) begin
      acc = 0;
      for (int k = 0; k < V; k++)
        acc += longint'($signed(fm_mem[k])) * longint'($signed(w_mem[c * V + k]));
      acc += longint'($signed(w_mem[N * V + c])) * 65536;
      r = (acc + 32768) >>> 16;
      if (r > 524287)       exp_s[c] = 20'h7FFFF;
      else if (r < -524288) exp_s[c] = 20'h80000;
      else                  exp_s[c] = r[19:0];
    end
    exp_idx = 0;
    for (int c = 1; c < N; c++)
      if ($signed(exp_s[c]) > $signed(exp_s[exp_idx])) exp_idx = c;
  endfunction

  task automatic fill(input logic [19:0] fmv, input logic [19:0] w0, w1, w2, w3,
                      input logic [19:0] b0, b1, b2, b3);
    for (int k = 0; k < V; k++) begin
      fm_mem[k]       = fmv;
      w_mem[k]        = w0;
      w_mem[V + k]    = w1;
      w_mem[2*V + k]  = w2;
      w_mem[3*V + k]  = w3;
    end
    for (int k = N * V; k < (1 << WAW); k++) w_mem[k] = '0;
    w_mem[N*V] = b0; w_mem[N*V+1] = b1; w_mem[N*V+2] = b2; w_mem[N*V+3] = b3;
  endtask

  function automatic logic [19:0] srnd(input int lim);
    return 20'(int'($urandom_range(2 * lim)) - lim);
  endfunction

  task automatic fill_rand(input int lim);
    for (int k = 0; k < V; k++) fm_mem[k] = srnd(lim);
    for (int k = 0; k < N * V; k++) w_mem[k] = srnd(lim);
    for (int k = N * V; k < (1 << WAW); k++) w_mem[k] = srnd(20'h3FFFF);
  endtask

  // Start at cycle 0 and wait for done; optional extra starts at 5 and 4000.
  task automatic run(input bit poke, input int abort_at, output int dcyc);
    @(posedge clk); #1;
    start = 1'b1; g_t0 = cyc;
    dcyc = -1;
    for (int n = 0; n < 9000 && dcyc < 0; n++) begin
      @(posedge clk); #1;
      start = poke && (cyc - g_t0 == 5 || cyc - g_t0 == 4000);
      if (abort_at > 0 && cyc - g_t0 == abort_at) break;
      if (done) dcyc = cyc - g_t0;
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string tag, input int dcyc);
    chk({tag, " done_cyc"}, 64'(dcyc), 64'(N * PER + 1));
    chk({tag, " n_res"}, 64'(r_data.size()), 64'(N));
    for (int c = 0; c < N && c < r_data.size(); c++) begin
      chk({tag, $sformatf(" res_addr%0d", c)}, 64'(r_addr[c]), 64'(c));
      chk({tag, $sformatf(" score%0d", c)}, 64'(r_data[c]), 64'(exp_s[c]));
      chk({tag, $sformatf(" res_cyc%0d", c)}, 64'(r_cyc[c] - g_t0), 64'(PER * (c + 1)));
    end
    chk({tag, " class_idx"}, 64'(class_idx), 64'(exp_idx));
    chk({tag, " sweep_err"}, 64'(sweep_err), 64'(0));
    chk({tag, " fm_cnt"}, 64'(fm_cnt), 64'(N * V));
    for (int c = 0; c < N; c++) chk({tag, $sformatf(" bias_rd%0d", c)}, 64'(bias_cnt[c]), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " idle busy/done"}, 64'({busy, done}), 64'(0));
    chk({tag, " idx hold"}, 64'(class_idx), 64'(exp_idx));
  endtask

  initial begin
    int d;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outs", outs, 64'(0));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle outs", outs, 64'(0));

    fill(20'h10000, 20'h00010, 20'h00040, 20'h00200, 20'hFFC00, 0, 0, 0, 0);
    model();
    run(1'b0, 0, d);
    check_run("normal", d);
    chk("normal s2 sat_hi", 64'(exp_s[2]), 64'(20'h7FFFF));
    chk("normal idx", 64'(class_idx), 64'(2));

    fill(0, 0, 0, 0, 0, 0, 0, 0, 0);
    fm_mem[0] = 20'h00001; w_mem[0] = 20'h08000;
    model();
    run(1'b0, 0, d);
    check_run("round_up", d);
    chk("round_up s0", 64'(r_data.size() > 0 ? r_data[0] : 20'hxxxxx), 64'(20'h00001));
    w_mem[0] = 20'h07FFF;
    model();
    run(1'b0, 0, d);
    check_run("round_dn", d);

    fill(20'h10000, 0, 0, 0, 0, 20'h01310, 20'hF7295, 20'h01310, 20'h00000);
    model();
    run(1'b0, 0, d);
    check_run("bias_tie", d);
    chk("bias_tie idx", 64'(class_idx), 64'(0));

    fill_rand(20'h00FFF);
    model();
    run(1'b1, 0, d);
    check_run("rand_poke", d);

    fill_rand(20'h03FFF);
    model();
    run(1'b0, 0, d);
    check_run("rand", d);

    fill(20'h10000, 20'h00010, 20'h00040, 20'h00200, 20'hFFC00, 0, 0, 0, 0);
    model();
    run(1'b0, 3000, d);
    chk("pre_reset fm_rd", 64'(fm_rd), 64'(1));
    reset = 1'b0;
    #1;
    chk("mid_reset outs", outs, 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    run(1'b0, 0, d);
    check_run("after_reset", d);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
